// File: rtl/sample_feeder_pkg.sv
// rtl/sample_feeder_pkg.sv - shared filter-path defaults and feeder state encoding
package sample_feeder_pkg;

  localparam int DATA_W_DEF = 12;
  localparam int ADDR_W_DEF = 10;
  localparam int PRESC_W    = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } feeder_state_t;

endpackage

// File: rtl/sample_feeder_ram.sv
// rtl/sample_feeder_ram.sv - simple dual-port read-first sample memory, synchronous read
module sample_ram
  import sample_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rd_data;

  // Non-blocking read and write in one block give old data on a same-address collision.
  always_ff @(posedge clk) begin
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - plays stored samples into the IIR cascade at one sample per DIV clocks
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DIV        = 1,
  parameter int OFFSET_BIN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   len,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);

  feeder_state_t       r_state;
  logic [ADDR_W:0]     r_len;
  logic                r_loop;
  logic [ADDR_W-1:0]   r_addr;
  logic [PRESC_W-1:0]  r_presc;
  logic                r_rd_pend;
  logic                r_rd_last;
  logic [DATA_W-1:0]   r_dout;
  logic                r_dout_valid;
  logic                r_done;

  logic                w_rd_issue;
  logic                w_at_last;
  logic [DATA_W-1:0]   w_ram_q;
  logic [DATA_W-1:0]   w_conv;

  // A stop in the same cycle kills the read before it is issued.
  assign w_rd_issue = (r_state == ST_RUN) && (r_presc == '0) && !stop;
  assign w_at_last  = ({1'b0, r_addr} == (r_len - (ADDR_W+1)'(1)));

  always_comb begin
    w_conv = w_ram_q;
    if (OFFSET_BIN != 0) w_conv[DATA_W-1] = ~w_ram_q[DATA_W-1];
  end

  sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_en   (w_rd_issue),
    .i_rd_addr (r_addr),
    .o_rd_data (w_ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_len        <= '0;
      r_loop       <= 1'b0;
      r_addr       <= '0;
      r_presc      <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_last    <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_rd_pend    <= w_rd_issue;
      r_rd_last    <= w_rd_issue && w_at_last && !r_loop;
      r_dout_valid <= r_rd_pend;
      if (r_rd_pend) r_dout <= w_conv;

      case (r_state)
        ST_IDLE: begin
          if (start && !stop && (len != '0)) begin
            r_state <= ST_RUN;
            r_len   <= len;
            r_loop  <= loop_en;
            r_addr  <= '0;
            r_presc <= '0;
            r_done  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_IDLE;
          end else begin
            r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
            if (w_rd_issue) begin
              if (w_at_last) begin
                r_addr <= '0;
                if (!r_loop) r_state <= ST_IDLE;
              end else begin
                r_addr <= r_addr + 1'b1;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // The final response of a one-shot run lands with its dout_valid.
      if (r_rd_pend && r_rd_last) r_done <= 1'b1;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign busy       = (r_state == ST_RUN) || r_rd_pend;
  assign done       = r_done;

endmodule

// File: tb/tb_sample_feeder.sv
// tb/tb_sample_feeder.sv - directed bench for sample_feeder
module tb_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [11:0] wr_data;

  logic [10:0] len0, len3, lenb;
  logic        loop0, loop3, loopb;
  logic        start0, start3, startb;
  logic        stop0, stop3, stopb;
  logic [11:0] dout0, dout3, doutb;
  logic        dv0, dv3, dvb;
  logic        busy0, busy3, busyb;
  logic        done0, done3, doneb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sample_feeder #(.DIV(1), .OFFSET_BIN(0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len0), .loop_en(loop0), .start(start0), .stop(stop0),
    .dout(dout0), .dout_valid(dv0), .busy(busy0), .done(done0));

  sample_feeder #(.DIV(3), .OFFSET_BIN(0)) u3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len3), .loop_en(loop3), .start(start3), .stop(stop3),
    .dout(dout3), .dout_valid(dv3), .busy(busy3), .done(done3));

  sample_feeder #(.DIV(1), .OFFSET_BIN(1)) ub (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(lenb), .loop_en(loopb), .start(startb), .stop(stopb),
    .dout(doutb), .dout_valid(dvb), .busy(busyb), .done(doneb));

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input logic [9:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    len0 = '0; len3 = '0; lenb = '0;
    loop0 = 0; loop3 = 0; loopb = 0;
    start0 = 0; start3 = 0; startb = 0;
    stop0 = 0; stop3 = 0; stopb = 0;
    tick(); tick();
    check("rst_dout", dout0, 12'h000);
    check("rst_valid", dv0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) write_mem(10'(i), 12'(i + 1));

    // One-shot, DIV=1
    len0 = 11'd4; loop0 = 0; start0 = 1; tick(); start0 = 0;
    check("os_busy_e0", busy0, 1'b1);
    check("os_valid_e0", dv0, 1'b0);
    tick();
    check("os_valid_e1", dv0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("os_valid", dv0, 1'b1);
      check("os_dout", dout0, 12'(k));
      check("os_done", done0, (k == 4) ? 1'b1 : 1'b0);
    end
    check("os_busy_end", busy0, 1'b0);
    tick();
    check("os_valid_after", dv0, 1'b0);
    check("os_dout_hold", dout0, 12'h004);
    check("os_done_sticky", done0, 1'b1);

    // Looping, DIV=3
    len3 = 11'd4; loop3 = 1; start3 = 1; tick(); start3 = 0;
    for (int n = 1; n <= 14; n++) begin
      logic ev;
      tick();
      ev = (n >= 2) && ((n - 2) % 3 == 0);
      check("loop_valid", dv3, ev);
      if (ev) check("loop_dout", dout3, 12'(((n - 2) / 3) % 4 + 1));
    end
    stop3 = 1; tick(); stop3 = 0;
    check("loop_stop_busy", busy3, 1'b0);
    for (int n = 0; n < 4; n++) begin
      tick();
      check("loop_stop_valid", dv3, 1'b0);
    end

    // Stop after second sample, DIV=3
    loop3 = 0; start3 = 1; tick(); start3 = 0;
    for (int n = 1; n <= 5; n++) tick();
    check("stop_pre_valid", dv3, 1'b1);
    check("stop_pre_dout", dout3, 12'h002);
    stop3 = 1; tick(); stop3 = 0;
    for (int n = 0; n < 6; n++) begin
      check("stop_valid", dv3, 1'b0);
      tick();
    end
    check("stop_dout_hold", dout3, 12'h002);
    check("stop_done", done3, 1'b0);
    check("stop_busy", busy3, 1'b0);

    // Offset-binary conversion
    write_mem(10'd0, 12'h800);
    lenb = 11'd1; loopb = 0; startb = 1; tick(); startb = 0;
    tick(); tick();
    check("ob_valid_800", dvb, 1'b1);
    check("ob_dout_800", doutb, 12'h000);
    check("ob_done", doneb, 1'b1);
    write_mem(10'd0, 12'h7FF);
    startb = 1; tick(); startb = 0;
    tick(); tick();
    check("ob_valid_7ff", dvb, 1'b1);
    check("ob_dout_7ff", doutb, 12'hFFF);

    // Ignored starts
    len0 = 11'd0; start0 = 1; tick(); start0 = 0;
    check("len0_busy_a", busy0, 1'b0);
    tick();
    check("len0_busy_b", busy0, 1'b0);
    len0 = 11'd4; start0 = 1; stop0 = 1; tick(); start0 = 0; stop0 = 0;
    check("ss_busy_a", busy0, 1'b0);
    tick(); tick();
    check("ss_busy_b", busy0, 1'b0);
    check("ss_valid", dv0, 1'b0);

    // Reset while a read is issued
    len0 = 11'd4; start0 = 1; tick(); start0 = 0;
    tick(); tick();
    check("rr_pre_valid", dv0, 1'b1);
    rst = 1; tick(); rst = 0;
    check("rr_valid", dv0, 1'b0);
    check("rr_dout", dout0, 12'h000);
    check("rr_busy", busy0, 1'b0);
    check("rr_done", done0, 1'b0);
    tick();
    check("rr_valid_next", dv0, 1'b0);

    // Same-address write during read returns old data
    len0 = 11'd1; start0 = 1; tick(); start0 = 0;
    write_mem(10'd0, 12'h123);
    tick();
    check("rf_valid", dv0, 1'b1);
    check("rf_old", dout0, 12'h7FF);
    start0 = 1; tick(); start0 = 0;
    tick(); tick();
    check("rf_new", dout0, 12'h123);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
